// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory port arbiter.
// Requester ids, FSM state encoding and bus widths.
package mem_arb_pkg;

    localparam int ROW_W   = 7;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        REQ_TEMP = 2'd0,
        REQ_WIND = 2'd1,
        REQ_RES  = 2'd2
    } req_id_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin winner selection: search starts at the requester after last_grant.
// Purely combinational; the caller registers the result.
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_grant,
    output logic [1:0]         winner,
    output logic               any
);

    always_comb begin
        winner = 2'd0;
        any    = |req;
        // Walk farthest-first so the nearest pending requester is assigned last and wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (req[idx]) begin
                winner = 2'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-requester memory port arbiter with round-robin grants and burst limit.
// state   | meaning
// IDLE    | no owner; pick next requester, flag stray mem_ack
// BUSY    | grant_id owns the port until burst limit or request drop
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0][ROW_W-1:0] req_row,
    input  logic [NUM_REQ-1:0][ROW_W-1:0] req_col,
    input  logic [DATA_W-1:0]             res_wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          mem_req,
    output logic                          mem_rd_wr,
    output logic                          mem_tem_win,
    output logic [ROW_W-1:0]              mem_row,
    output logic [ROW_W-1:0]              mem_col,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    output logic                          grant_valid,
    output logic [1:0]                    grant_id,
    output logic                          protocol_err
);

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    arb_state_e state;
    logic [1:0] last_grant;
    logic [7:0] beat_cnt;
    logic [1:0] pick_id;
    logic       pick_any;
    logic       owner_req;

    rr_picker u_picker (
        .req        (req),
        .last_grant (last_grant),
        .winner     (pick_id),
        .any        (pick_any)
    );

    // Port mux follows the registered owner; everything is held at zero while IDLE.
    always_comb begin
        owner_req   = 1'b0;
        ack         = '0;
        mem_req     = 1'b0;
        mem_rd_wr   = 1'b0;
        mem_tem_win = 1'b0;
        mem_row     = '0;
        mem_col     = '0;
        mem_wdata   = '0;
        if (state == ST_BUSY) begin
            case (grant_id)
                REQ_TEMP: begin
                    owner_req = req[0];
                    ack[0]    = mem_ack;
                    mem_row   = req_row[0];
                    mem_col   = req_col[0];
                end
                REQ_WIND: begin
                    owner_req   = req[1];
                    ack[1]      = mem_ack;
                    mem_tem_win = 1'b1;
                    mem_row     = req_row[1];
                    mem_col     = req_col[1];
                end
                REQ_RES: begin
                    owner_req = req[2];
                    ack[2]    = mem_ack;
                    mem_rd_wr = 1'b1;
                    mem_row   = req_row[2];
                    mem_col   = req_col[2];
                    mem_wdata = res_wdata;
                end
                default: ;
            endcase
            mem_req = owner_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            grant_valid  <= 1'b0;
            grant_id     <= 2'd0;
            last_grant   <= 2'(REQ_RES);
            beat_cnt     <= 8'd0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_ack) begin
                        protocol_err <= 1'b1;
                    end
                    if (pick_any) begin
                        grant_id    <= pick_id;
                        grant_valid <= 1'b1;
                        beat_cnt    <= 8'd0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    if (!owner_req || (mem_ack && beat_cnt == LAST_BEAT)) begin
                        last_grant  <= grant_id;
                        grant_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16, SHALL set the maximum accepted beats per grant before forced rotation; legal range 1..255.
REQ-002 Ports clk, input, 1, rising-edge clock; rst, input, 1, asynchronous active-high reset. One clock; reset is asynchronous and active-high.
REQ-003 req, input, 3, per-requester access request; index 0 = template reader, 1 = window reader, 2 = result writer.
REQ-004 req_row, input, 3x7, row address per requester; req_col, input, 3x7, column address per requester.
REQ-005 res_wdata, input, 32, write data from requester 2.
REQ-006 ack, output, 3, one-hot per-requester beat acknowledge.
REQ-007 mem_req, output, 1, memory access request; mem_rd_wr, output, 1, 0 = read, 1 = write; mem_tem_win, output, 1, 0 = template space, 1 = window space.
REQ-008 mem_row, mem_col, output, 7 each, memory address; mem_wdata, output, 32, write data.
REQ-009 mem_ack, input, 1, memory beat complete (read data valid on the shared read bus that cycle).
REQ-010 grant_valid, output, 1, a requester owns the port; grant_id, output, 2, owning requester index.
REQ-011 protocol_err, output, 1, sticky error flag.

Function
REQ-012 FSM states: IDLE, BUSY.
REQ-013 IDLE: if any req bit is high, select a winner by round-robin starting at the index after last_grant (wrapping 2->0); register grant_id, set grant_valid, enter BUSY on the next edge (grant latency 1 cycle).
REQ-014 IDLE with req == 0: remain in IDLE; mem_req = 0.
REQ-015 BUSY: mem_req = req[grant_id]; mem_row/mem_col = that requester's row/col, combinationally muxed from the registered grant_id.
REQ-016 Access mapping: id 0 -> rd_wr 0, tem_win 0; id 1 -> rd_wr 0, tem_win 1; id 2 -> rd_wr 1, tem_win 0, mem_wdata = res_wdata; mem_wdata = 0 for ids 0 and 1.
REQ-017 ack[grant_id] = mem_ack while BUSY (same cycle, combinational); all other ack bits 0; ack = 0 in IDLE.
REQ-018 8-bit beat counter: cleared on grant, incremented on each mem_ack in BUSY.
REQ-019 Release: in BUSY, on mem_ack with beat count == MAX_BURST-1, or when req[grant_id] is low; last_grant <= grant_id, grant_valid <= 0, enter IDLE (one-cycle bubble before next grant).
REQ-020 mem_ack coincident with req[grant_id] falling: the beat is acknowledged and counted, then released.
REQ-021 MAX_BURST = 1: release after every beat; three continuous requesters are served 0,1,2,0,...
REQ-022 mem_ack while IDLE: ignored for ack, protocol_err <= 1.
REQ-023 A requester SHALL never be starved: each pending requester is granted within 2 grants of any other.

Reset
REQ-024 Asserting rst (any time, including mid-BUSY) SHALL asynchronously force: state IDLE, grant_valid 0, grant_id 0, last_grant 2 (requester 0 wins first), beat count 0, protocol_err 0; hence mem_req 0, ack 0, mem_rd_wr 0, mem_tem_win 0, mem_row/mem_col 0, mem_wdata 0.
REQ-025 An in-flight beat interrupted by reset is not acknowledged; requesters reissue.

Structure
REQ-026 Package mem_arb_pkg SHALL hold requester id enum (REQ_TEMP = 0, REQ_WIND = 1, REQ_RES = 2), ROW_W = 7, DATA_W = 32, NUM_REQ = 3.
REQ-027 One combinational sub-module rr_picker (req, last_grant -> winner, any) SHALL implement the round-robin selection.
REQ-028 All state, grant, counter and error registers in a single asynchronous-reset sequential process.

Verification
REQ-029 Reset then req = 3'b001, row 5, col 9, mem_ack every cycle -> grant_valid one cycle after req, mem_row 5, mem_col 9, rd_wr 0, tem_win 0, ack[0] mirrors mem_ack.
REQ-030 req = 3'b111 held, MAX_BURST = 4, mem_ack always 1 -> grants 0,1,2,0 each for exactly 4 acks, one IDLE cycle between grants.
REQ-031 Grant to id 2 with res_wdata 32'hDEADBEEF -> mem_rd_wr 1, mem_wdata 32'hDEADBEEF; then grant id 1 -> mem_tem_win 1, mem_wdata 0.
REQ-032 req[0] drops after 2 acks while req[1] pending -> release after the 2nd beat, id 1 granted 2 cycles later.
REQ-033 mem_ack pulsed with req = 0 -> protocol_err 1 and stays 1 until rst.
REQ-034 rst asserted mid-BUSY (beat count 3) -> mem_req and grant_valid fall immediately without a clock edge; after release, requester 0 wins first.
